// File: rtl/byte_striping_ctrl_if.sv
// Byte-stream input handshake and 4-lane striped word output of the striping controller.
// The master drives the byte stream; the slave (the controller) drives the lanes.
interface byte_striping_ctrl_if;
   logic [7:0] byteStripingIN;
   logic       byteStripingVLD;
   logic       byteStripingRDY;
   logic [7:0] stripedLane0;
   logic [7:0] stripedLane1;
   logic [7:0] stripedLane2;
   logic [7:0] stripedLane3;
   logic       stripedVLD;
   logic       stripedSKP;
   logic [3:0] padMask;

   modport master (
      output byteStripingIN, byteStripingVLD,
      input  byteStripingRDY,
      input  stripedLane0, stripedLane1, stripedLane2, stripedLane3,
      input  stripedVLD, stripedSKP, padMask
   );

   modport slave (
      input  byteStripingIN, byteStripingVLD,
      output byteStripingRDY,
      output stripedLane0, stripedLane1, stripedLane2, stripedLane3,
      output stripedVLD, stripedSKP, padMask
   );
endinterface

// File: rtl/byte_striping_ctrl.sv
// Round-robin byte striper: packs a byte stream into 4-lane words, pads partial
// groups when the stream pauses, and inserts a skip word every SKP_INTERVAL words.
module byte_striping_ctrl #(
   parameter int         SKP_INTERVAL = 8,
   parameter logic [7:0] PAD_SYM      = 8'h7C,
   parameter logic [7:0] SKP_SYM      = 8'h1C
) (
   input  logic                  byteStripingCLK,
   input  logic                  byteStripingRESET_L,
   byte_striping_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_SKIP = 2'd2
   } state_t;

   localparam logic [7:0] SKP_LAST = 8'(SKP_INTERVAL - 1);

   state_t     r_state;
   logic [1:0] r_lane_idx;
   logic [7:0] r_skp_cnt;
   logic [7:0] r_shadow [0:2];
   logic [7:0] r_lane   [0:3];
   logic       r_vld;
   logic       r_skp;
   logic [3:0] r_pad_mask;

   logic       w_rdy;
   logic       w_accept;
   logic       w_skp_hit;
   logic [3:0] w_pad_mask;
   logic [7:0] w_word_lane [0:3];

   assign w_rdy     = (r_state != ST_SKIP);
   assign w_accept  = bus.byteStripingVLD && w_rdy;
   assign w_skp_hit = (r_skp_cnt == SKP_LAST);

   // Word contents for either a completed group (4th byte arriving now) or a pad word.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_pad_mask[gi] = ({1'b0, r_lane_idx} <= 3'(gi));
         if (gi < 3) begin : g_held
            assign w_word_lane[gi] = (w_accept || !w_pad_mask[gi]) ? r_shadow[gi] : PAD_SYM;
         end else begin : g_last
            assign w_word_lane[gi] = w_accept ? bus.byteStripingIN : PAD_SYM;
         end
      end
   endgenerate

   always_ff @(posedge byteStripingCLK or negedge byteStripingRESET_L) begin
      if (!byteStripingRESET_L) begin
         r_state    <= ST_IDLE;
         r_lane_idx <= 2'd0;
         r_skp_cnt  <= 8'd0;
         r_vld      <= 1'b0;
         r_skp      <= 1'b0;
         r_pad_mask <= 4'b0000;
         for (int i = 0; i < 3; i++) r_shadow[i] <= 8'h00;
         for (int i = 0; i < 4; i++) r_lane[i] <= 8'h00;
      end else begin
         r_vld      <= 1'b0;
         r_skp      <= 1'b0;
         r_pad_mask <= 4'b0000;
         case (r_state)
            ST_SKIP: begin
               for (int i = 0; i < 4; i++) r_lane[i] <= SKP_SYM;
               r_vld     <= 1'b1;
               r_skp     <= 1'b1;
               r_skp_cnt <= 8'd0;
               r_state   <= ST_IDLE;
            end
            default: begin
               if (w_accept && (r_lane_idx != 2'd3)) begin
                  r_shadow[r_lane_idx] <= bus.byteStripingIN;
                  r_lane_idx           <= r_lane_idx + 2'd1;
                  r_state              <= ST_FILL;
               end else if (w_accept || (r_state == ST_FILL)) begin
                  // Either the group just completed or the stream paused mid-group.
                  for (int i = 0; i < 4; i++) r_lane[i] <= w_word_lane[i];
                  r_vld      <= 1'b1;
                  r_pad_mask <= w_accept ? 4'b0000 : w_pad_mask;
                  r_lane_idx <= 2'd0;
                  r_skp_cnt  <= r_skp_cnt + 8'd1;
                  r_state    <= w_skp_hit ? ST_SKIP : ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.byteStripingRDY = w_rdy;
   assign bus.stripedLane0    = r_lane[0];
   assign bus.stripedLane1    = r_lane[1];
   assign bus.stripedLane2    = r_lane[2];
   assign bus.stripedLane3    = r_lane[3];
   assign bus.stripedVLD      = r_vld;
   assign bus.stripedSKP      = r_skp;
   assign bus.padMask         = r_pad_mask;

endmodule
